uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter among `N_REQ` byte-producing requesters using round-robin arbitration. The block sits between the requesters and the transmitter's `dataReady`/`data`/`ReadyToSend` interface. It latches the winning byte and holds it stable for the entire frame. It also sequences the transmitter's tick-sampled handshake, so requesters never touch it directly.

## Interface
- `N_REQ`, 4: number of requesters, range 2..8.
- `START_TIMEOUT`, 32'd4096: maximum clock cycles to wait for the transmitter to accept a start request. Must exceed the transmitter divider + 2.
- `CLK_i`  input  1  system clock; all logic on its rising edge.
- `Reset_ni`  input  1  asynchronous, active-low reset.
- `req_valid_i`  input  N_REQ  per-requester "byte pending"; level, held until acked.
- `req_data_i`  input  8*N_REQ  byte k on bits [8k+7:8k].
- `req_ack_o`  output  N_REQ  one-cycle pulse: requester's byte accepted by transmitter.
- `tx_ready_i`  input  1  transmitter `ReadyToSend`.
- `tx_start_o`  output  1  drives transmitter `dataReady`.
- `tx_data_o`  output  8  drives transmitter `data`.
- `grant_o`  output  N_REQ  one-hot current owner; all-zero when idle.
- `busy_o`  output  1  high whenever state ≠ IDLE.
- `err_o`  output  1  one-cycle pulse on start timeout.

## Operation
- All outputs are registered.
- Reset values:
  - `tx_start_o`=0, `tx_data_o`=8'h00, `grant_o`=0, `req_ack_o`=0, `busy_o`=0, `err_o`=0.
  - State = IDLE, timeout counter = 0.
  - Round-robin pointer `last` = N_REQ-1, so requester 0 wins first.
- IDLE:
  - If any `req_valid_i` bit is set and `tx_ready_i`=1, pick the winner `g`. The winner is the first set bit searching `last+1, last+2, …` modulo N_REQ.
  - Register `grant_o`=onehot(g), `tx_data_o`=byte g, `tx_start_o`=1, `busy_o`=1, counter=0. Go to START.
  - If `tx_ready_i`=0, stay in IDLE. No grant is issued.
- START:
  - `tx_start_o` is held at 1 and the counter increments each cycle.
  - When `tx_ready_i`=0 is sampled: `tx_start_o`←0, `req_ack_o[g]`←1 for one cycle, `last`←g. Go to DONE.
  - Otherwise, when the counter reaches `START_TIMEOUT`-1: `tx_start_o`←0, `grant_o`←0, `busy_o`←0, `err_o`←1 for one cycle. Go to IDLE. No ack is issued, and `last` is unchanged, so the same requester is retried first.
- DONE:
  - Wait until `tx_ready_i`=1 is sampled, then `grant_o`←0, `busy_o`←0. Go to IDLE.
- `tx_data_o` changes only on the IDLE→START transition. It is stable from the start request through the stop bit.
- If `req_valid_i[g]` drops after the grant, the latched byte is still sent and still acked. Requesters must not rely on withdrawing a request.
- A requester that re-asserts valid right after its ack competes normally. Round-robin guarantees each of the other pending requesters is served before it again.
- `req_data_i` is sampled only in the IDLE cycle that grants.
- `tx_start_o` must be low before the transmitter returns to its idle state. This prevents a duplicate frame.

## Timing
- Cycle T: IDLE, valid and ready both seen. At T+1, `tx_start_o`, `grant_o` and `tx_data_o` are valid.
- Transmitter drops ready at cycle A (the next baud tick). At A+1, `tx_start_o`=0 and `req_ack_o` pulses.
- Ready rises at cycle R (start of stop bit). At R+1 the block is in IDLE. The earliest next grant is at R+2.
- Back-to-back frames are limited only by the transmitter. The arbiter adds 2 clock cycles per frame.
- Reset assertion mid-frame forces all outputs to reset values immediately.
  - `tx_start_o` drops, but the transmitter may finish the frame with its latched state.
  - After release, the block waits for `tx_ready_i`=1 before granting.

## Test plan
- **Single request:** req 2 valid with byte 8'hA5, transmitter model with divider 8.
  - `grant_o`=4'b0100 and `tx_start_o`=1 one cycle after valid.
  - `tx_data_o`=8'hA5 throughout the frame.
  - One `req_ack_o[2]` pulse.
  - Line carries 0,1,0,1,0,0,1,0,1 then stop.
- **Round-robin fairness:** all 4 valid continuously for 8 frames.
  - Grant order is 0,1,2,3,0,1,2,3.
  - Exactly one ack per frame, one cycle after ready falls.
- **Sparse requests:** last=1; requesters 0 and 3 valid. Grant goes to 3, then 0.
- **Start timeout:** `tx_ready_i` tied high with `START_TIMEOUT`=16.
  - `err_o` pulses exactly 16 cycles after `tx_start_o` rises.
  - No ack is issued.
  - Next grant goes to the same requester.
- **Withdrawn request:** req 1 drops valid the cycle after grant. The byte is still transmitted and `req_ack_o[1]` still pulses.
- **Reset mid-frame:** assert `Reset_ni`=0 during DONE.
  - All outputs are 0 in the same cycle.
  - After release with `tx_ready_i`=0, no grant occurs until ready returns to 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Latches the winning byte for the whole frame and runs the tick-sampled start handshake.
module uart_tx_arbiter #(
    parameter int          N_REQ         = 4,
    parameter logic [31:0] START_TIMEOUT = 32'd4096
) (
    input  logic               CLK_i,
    input  logic               Reset_ni,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ack_o,
    input  logic               tx_ready_i,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               err_o
);

    // state   | meaning
    // S_IDLE  | no owner; grant when a request is pending and the transmitter is ready
    // S_START | start request held high until the transmitter drops ready (or timeout)
    // S_DONE  | frame in flight; wait for ready to return at the stop bit
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int IW = $clog2(N_REQ);

    state_t             r_state, w_state_nxt;
    logic [IW-1:0]      r_last, w_last_nxt;
    logic [IW-1:0]      r_gidx, w_gidx_nxt;
    logic [31:0]        r_cnt, w_cnt_nxt;
    logic               r_tx_start, w_tx_start_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [N_REQ-1:0]   r_ack, w_ack_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_err, w_err_nxt;

    logic               w_any;
    logic               w_hi_found;
    logic [IW-1:0]      w_hi_idx, w_lo_idx, w_win_idx;
    logic [7:0]         w_hi_byte, w_lo_byte, w_win_byte;
    logic [N_REQ-1:0]   w_win_oh;

    assign w_any = |req_valid_i;

    // Lowest set index above r_last wins; otherwise wrap to the lowest set index overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_byte  = '0;
        w_lo_byte  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                if (i > int'(r_last)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IW'(i);
                    w_hi_byte  = req_data_i[8*i +: 8];
                end else begin
                    w_lo_idx   = IW'(i);
                    w_lo_byte  = req_data_i[8*i +: 8];
                end
            end
        end
        w_win_idx  = w_hi_found ? w_hi_idx  : w_lo_idx;
        w_win_byte = w_hi_found ? w_hi_byte : w_lo_byte;
        w_win_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
    end

    always_ff @(posedge CLK_i or negedge Reset_ni) begin
        if (!Reset_ni) begin
            r_state    <= S_IDLE;
            r_last     <= IW'(N_REQ - 1);
            r_gidx     <= '0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_grant    <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_gidx     <= w_gidx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_grant    <= w_grant_nxt;
            r_ack      <= w_ack_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_gidx_nxt     = r_gidx;
        w_cnt_nxt      = r_cnt;
        w_tx_start_nxt = r_tx_start;
        w_tx_data_nxt  = r_tx_data;
        w_grant_nxt    = r_grant;
        w_busy_nxt     = r_busy;
        w_ack_nxt      = '0;
        w_err_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any && tx_ready_i) begin
                    w_gidx_nxt     = w_win_idx;
                    w_grant_nxt    = w_win_oh;
                    w_tx_data_nxt  = w_win_byte;
                    w_tx_start_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_START;
                end
            end
            S_START: begin
                if (!tx_ready_i) begin
                    w_tx_start_nxt = 1'b0;
                    w_ack_nxt      = r_grant;
                    w_last_nxt     = r_gidx;
                    w_state_nxt    = S_DONE;
                end else if (r_cnt == START_TIMEOUT - 32'd1) begin
                    // r_last untouched so the same requester is retried first
                    w_tx_start_nxt = 1'b0;
                    w_grant_nxt    = '0;
                    w_busy_nxt     = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_cnt_nxt      = r_cnt + 32'd1;
                end
            end
            S_DONE: begin
                if (tx_ready_i) begin
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx_start_o = r_tx_start;
    assign tx_data_o  = r_tx_data;
    assign grant_o    = r_grant;
    assign req_ack_o  = r_ack;
    assign busy_o     = r_busy;
    assign err_o      = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps, per-requester byte queues, a divider-8
// transmitter model and an expected-grant scoreboard popped on every ack.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   valid = '0;
    logic [8*N-1:0] data  = '0;
    logic [N-1:0]   ack, grant;
    logic           tx_ready, tx_start, busy, err;
    logic [7:0]     tx_data;

    logic           tm_en   = 1'b1;
    logic           rdy_ovr = 1'b1;
    logic [N-1:0]   wd      = '0;
    logic [N-1:0]   qv;

    logic           m_rdy   = 1'b1;
    logic           m_busy  = 1'b0;
    logic [3:0]     m_bit   = '0;
    logic [2:0]     m_div   = '0;
    logic [9:0]     m_frame = '0;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] rxexp_q[$];
    logic [7:0] rx_e;
    logic       line_q[$];
    logic [7:0] rq[N][$];
    logic       rdy_h1 = 1'b0;
    logic       rdy_h2 = 1'b0;
    logic [N-1:0] prev_grant = '0;
    logic [7:0]   prev_data  = '0;

    always #5 clk = ~clk;
    assign tx_ready = tm_en ? m_rdy : rdy_ovr;

    uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(32'd16)) dut (
        .CLK_i       (clk),
        .Reset_ni    (rst_n),
        .req_valid_i (valid),
        .req_data_i  (data),
        .req_ack_o   (ack),
        .tx_ready_i  (tx_ready),
        .tx_start_o  (tx_start),
        .tx_data_o   (tx_data),
        .grant_o     (grant),
        .busy_o      (busy),
        .err_o       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || rxexp_q.size() != 0 || busy || m_busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 32'(c < budget), 32'd1);
    endtask

    // Requesters: each presents the head of its byte queue, popping it on ack.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst_n && ack[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            qv[k] = (rq[k].size() > 0);
            data[8*k +: 8] = qv[k] ? rq[k][0] : 8'h00;
        end
        valid = qv & ~wd;
    end

    // Transmitter: samples dataReady on each baud tick, drops ready for start..data bits.
    always @(posedge clk) begin
        m_div <= m_div + 3'd1;
        if (m_div == 3'd7) begin
            if (tm_en && m_rdy && tx_start) begin
                m_frame <= {1'b1, tx_data, 1'b0};
                m_bit   <= 4'd0;
                m_busy  <= 1'b1;
                m_rdy   <= 1'b0;
                line_q.push_back(1'b0);
            end else if (m_busy) begin
                if (m_bit == 4'd9) begin
                    m_busy <= 1'b0;
                end else begin
                    m_bit <= m_bit + 4'd1;
                    line_q.push_back(m_frame[m_bit + 4'd1]);
                    if (m_bit == 4'd8) begin
                        m_rdy <= 1'b1;
                        if (rxexp_q.size() == 0) chk("unexpected_frame", 32'(m_frame[8:1]), 32'hFFFF_FFFF);
                        else begin
                            rx_e = rxexp_q.pop_front();
                            chk("rx_byte", 32'(m_frame[8:1]), 32'(rx_e));
                        end
                    end
                end
            end
        end
    end

    // Scoreboard: every ack pops the expected owner/byte.
    always @(negedge clk) begin
        if (rst_n && ack != '0) begin
            if (exp_q.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("ack_onehot", 32'(ack), 32'd1 << mon_e.idx);
                chk("ack_data", 32'(tx_data), 32'(mon_e.d));
                chk("ack_one_cycle_after_ready_fall", {30'd0, rdy_h2, rdy_h1}, 32'd2);
                chk("start_low_at_ack", 32'(tx_start), 32'd0);
                rxexp_q.push_back(mon_e.d);
            end
        end
        if (rst_n && busy && grant != '0 && grant == prev_grant)
            chk("data_stable", 32'(tx_data), 32'(prev_data));
        rdy_h2 = rdy_h1;
        rdy_h1 = tx_ready;
        prev_grant = grant;
        prev_data  = tx_data;
    end

    initial begin
        int n;
        logic seen;
        logic [9:0] exp_line;

        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // single request
        @(posedge clk); #1;
        line_q.delete();
        rq[2].push_back(8'hA5);
        exp_q.push_back('{idx: 3'd2, d: 8'hA5});
        @(posedge clk); @(negedge clk);
        chk("single_grant", 32'(grant), 32'b0100);
        chk("single_start", 32'(tx_start), 32'd1);
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_busy", 32'(busy), 32'd1);
        wait_done("single_done", 1000);
        exp_line = {1'b1, 8'hA5, 1'b0};
        chk("single_line_len", 32'(line_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < line_q.size(); i++)
            chk("single_line_bit", 32'(line_q[i]), 32'(exp_line[i]));

        // round-robin fairness from a fresh pointer
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int f = 0; f < 8; f++) begin
            rq[f % 4].push_back(8'h10 + 8'(f));
            exp_q.push_back('{idx: 3'(f % 4), d: 8'h10 + 8'(f)});
        end
        wait_done("rr_done", 3000);

        // sparse: bring last to 1, then 0 and 3 pending
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        rq[0].push_back(8'h31);
        exp_q.push_back('{idx: 3'd0, d: 8'h31});
        wait_done("sparse_pre0", 1000);
        @(posedge clk); #1;
        rq[1].push_back(8'h32);
        exp_q.push_back('{idx: 3'd1, d: 8'h32});
        wait_done("sparse_pre1", 1000);
        @(posedge clk); #1;
        rq[0].push_back(8'h40);
        rq[3].push_back(8'h43);
        exp_q.push_back('{idx: 3'd3, d: 8'h43});
        exp_q.push_back('{idx: 3'd0, d: 8'h40});
        @(posedge clk); @(negedge clk);
        chk("sparse_first_grant", 32'(grant), 32'b1000);
        wait_done("sparse_done", 2000);

        // start timeout: transmitter never accepts
        @(posedge clk); #1;
        tm_en   = 1'b0;
        rdy_ovr = 1'b1;
        rq[2].push_back(8'h3C);
        n = 0;
        while (!tx_start && n < 50) begin @(negedge clk); n++; end
        chk("to_start_seen", 32'(tx_start), 32'd1);
        n = 0;
        while (!err && n < 40) begin @(negedge clk); n++; end
        chk("to_err_delay", 32'(n), 32'd16);
        chk("to_grant_cleared", 32'(grant), 32'd0);
        chk("to_busy_cleared", 32'(busy), 32'd0);
        @(negedge clk);
        chk("to_err_one_cycle", 32'(err), 32'd0);
        chk("to_regrant_same", 32'(grant), 32'b0100);
        @(posedge clk); #1;
        exp_q.push_back('{idx: 3'd2, d: 8'h3C});
        tm_en = 1'b1;
        wait_done("to_done", 1000);

        // withdrawn request
        @(posedge clk); #1;
        rq[1].push_back(8'h5A);
        exp_q.push_back('{idx: 3'd1, d: 8'h5A});
        n = 0;
        while (!grant[1] && n < 50) begin @(negedge clk); n++; end
        chk("wd_grant_seen", 32'(grant), 32'b0010);
        @(posedge clk); #1;
        wd = 4'b0010;
        wait_done("wd_done", 1000);
        wd = '0;

        // reset mid-frame, released with the transmitter not ready
        @(posedge clk); #1;
        rq[0].push_back(8'hC3);
        exp_q.push_back('{idx: 3'd0, d: 8'hC3});
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk); @(negedge clk);
        chk("rf_in_done", {30'd0, busy, tx_start}, 32'd2);
        tm_en   = 1'b0;
        rdy_ovr = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rf_tx_start", 32'(tx_start), 32'd0);
        chk("rf_tx_data", 32'(tx_data), 32'd0);
        chk("rf_grant", 32'(grant), 32'd0);
        chk("rf_busy", 32'(busy), 32'd0);
        chk("rf_ack_err", {30'd0, |ack, err}, 32'd0);
        rq[3].push_back(8'h77);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant != '0 || tx_start) seen = 1'b1;
        end
        chk("rf_no_grant_until_ready", 32'(seen), 32'd0);
        n = 0;
        while ((m_busy || rxexp_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
        chk("rf_prev_frame_finished", 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        exp_q.push_back('{idx: 3'd3, d: 8'h77});
        rdy_ovr = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rf_grant_after_ready", 32'(grant), 32'b1000);
        @(posedge clk); #1;
        tm_en = 1'b1;
        wait_done("rf_done", 1000);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
